// File: rtl/factorial_unit_if.sv
// Start/done handshake bundle between a controller and the factorial engine.
interface factorial_unit_if #(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned N_WIDTH = 8
);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic               ready;
  logic               busy;
  logic               done;
  logic [WIDTH-1:0]   f;
  logic               overflow;

  modport master (
    output start, n,
    input  ready, busy, done, f, overflow
  );

  modport slave (
    input  start, n,
    output ready, busy, done, f, overflow
  );
endinterface

// File: rtl/factorial_unit.sv
// Iterative n! engine: one multiply per clock, sticky overflow, optional saturation.
// Result and overflow are held in output registers between completions.
module factorial_unit #(
  parameter int unsigned WIDTH    = 32,
  parameter int unsigned N_WIDTH  = 8,
  parameter bit          SATURATE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  factorial_unit_if.slave   bus
);

  localparam int unsigned P_W = WIDTH + N_WIDTH;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   acc_q, acc_d;
  logic [N_WIDTH-1:0] cnt_q, cnt_d;
  logic               ovf_q, ovf_d;
  logic [WIDTH-1:0]   f_q, f_d;
  logic               ovf_out_q, ovf_out_d;
  logic [P_W-1:0]     prod_c;
  logic               prod_hi_c;

  // Full-width product; any bit above WIDTH means the true value no longer fits.
  assign prod_c    = P_W'(acc_q) * P_W'(cnt_q);
  assign prod_hi_c = |prod_c[P_W-1:WIDTH];

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    f_d       = f_q;
    ovf_out_d = ovf_out_q;
    case (state_q)
      S_IDLE: begin
        if (bus.start) begin
          acc_d   = WIDTH'(1);
          cnt_d   = bus.n;
          ovf_d   = 1'b0;
          state_d = S_MUL;
        end
      end
      S_MUL: begin
        // Exit test precedes the decrement, so cnt never drops below 1.
        if (cnt_q > N_WIDTH'(1)) begin
          acc_d = prod_c[WIDTH-1:0];
          ovf_d = ovf_q | prod_hi_c;
          cnt_d = cnt_q - N_WIDTH'(1);
        end else begin
          f_d       = (SATURATE && ovf_q) ? {WIDTH{1'b1}} : acc_q;
          ovf_out_d = ovf_q;
          state_d   = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      acc_q     <= WIDTH'(1);
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      f_q       <= '0;
      ovf_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      f_q       <= f_d;
      ovf_out_q <= ovf_out_d;
    end
  end

  assign bus.ready    = (state_q == S_IDLE);
  assign bus.busy     = (state_q == S_MUL);
  assign bus.done     = (state_q == S_DONE);
  assign bus.f        = f_q;
  assign bus.overflow = ovf_out_q;

endmodule

// File: tb/tb_factorial_unit.sv
// Scoreboard bench: three engine variants share one stimulus stream and are
// checked against an arithmetic factorial model on every done pulse.
module tb_factorial_unit;

  logic clk;
  logic rst;
  int unsigned cyc;
  int total;
  int bad;

  typedef struct {
    logic [31:0] f32;
    logic        o32;
    logic [31:0] fs;
    logic        os;
    logic [31:0] f8;
    logic        o8;
    int unsigned dcyc;
    int unsigned lat;
  } exp_t;

  exp_t sb_q[$];

  factorial_unit_if #(.WIDTH(32), .N_WIDTH(8)) if32 ();
  factorial_unit_if #(.WIDTH(32), .N_WIDTH(8)) ifs ();
  factorial_unit_if #(.WIDTH(8),  .N_WIDTH(8)) if8 ();

  assign ifs.start = if32.start;
  assign ifs.n     = if32.n;
  assign if8.start = if32.start;
  assign if8.n     = if32.n;

  factorial_unit #(.WIDTH(32), .N_WIDTH(8), .SATURATE(1'b0)) u_w32 (
    .clk(clk), .rst(rst), .bus(if32));
  factorial_unit #(.WIDTH(32), .N_WIDTH(8), .SATURATE(1'b1)) u_sat (
    .clk(clk), .rst(rst), .bus(ifs));
  factorial_unit #(.WIDTH(8),  .N_WIDTH(8), .SATURATE(1'b0)) u_w8 (
    .clk(clk), .rst(rst), .bus(if8));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  // n! computed in ascending order; overflow from the true (unwrapped) value.
  function automatic void fact_ref(input int unsigned n, input int unsigned w, input bit sat,
                                   output logic [31:0] f, output logic o);
    longint unsigned mask;
    longint unsigned m;
    longint unsigned r;
    mask = (64'd1 << w) - 64'd1;
    m = 1;
    r = 1;
    o = 1'b0;
    for (int unsigned k = 2; k <= n; k++) begin
      m = (m * k) & mask;
      if (!o) begin
        r = r * k;
        if ((r >> w) != 0) o = 1'b1;
      end
    end
    f = (sat && o) ? 32'(mask) : 32'(m);
  endfunction

  task automatic wait_ready();
    int k;
    k = 0;
    while (!if32.ready && k < 600) begin
      @(negedge clk);
      k++;
    end
    chk("ready_wait", 64'(if32.ready), 64'd1);
  endtask

  task automatic do_op(input int unsigned nv, input bit hold);
    exp_t e;
    int k;
    wait_ready();
    fact_ref(nv, 32, 1'b0, e.f32, e.o32);
    fact_ref(nv, 32, 1'b1, e.fs,  e.os);
    fact_ref(nv, 8,  1'b0, e.f8,  e.o8);
    e.lat  = (nv > 1) ? nv : 1;
    e.dcyc = cyc + 1 + e.lat;
    sb_q.push_back(e);
    if32.start = 1'b1;
    if32.n     = 8'(nv);
    @(negedge clk);
    if (hold) begin
      k = 0;
      while (!if32.done && k < 600) begin
        if32.n = 8'($urandom);
        @(negedge clk);
        k++;
      end
      chk("hold_done_seen", 64'(if32.done), 64'd1);
    end
    if32.start = 1'b0;
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb_q.size() != 0 && k < 2000) begin
      @(negedge clk);
      k++;
    end
    chk("drain", 64'(sb_q.size()), 64'd0);
  endtask

  // Monitor: pops an expectation on each done pulse, checks hold/latency otherwise.
  logic [31:0] held32, helds, held8;
  logic        heldo32, heldos, heldo8;
  int unsigned busy_cnt;
  bit          prev_done;

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      held32 = '0; helds = '0; held8 = '0;
      heldo32 = 1'b0; heldos = 1'b0; heldo8 = 1'b0;
      busy_cnt = 0;
      prev_done = 1'b0;
    end else begin
      if (prev_done) chk("ready_after_done", 64'(if32.ready), 64'd1);
      if (if32.busy) busy_cnt++;
      if (if32.done) begin
        if (sb_q.size() == 0) begin
          chk("unexpected_done", 64'd1, 64'd0);
        end else begin
          e = sb_q.pop_front();
          chk("f_w32",      64'(if32.f),        64'(e.f32));
          chk("ovf_w32",    64'(if32.overflow), 64'(e.o32));
          chk("f_sat",      64'(ifs.f),         64'(e.fs));
          chk("ovf_sat",    64'(ifs.overflow),  64'(e.os));
          chk("f_w8",       64'(if8.f),         64'(e.f8));
          chk("ovf_w8",     64'(if8.overflow),  64'(e.o8));
          chk("done_align", 64'({ifs.done, if8.done}), 64'd3);
          chk("done_cycle", 64'(cyc),           64'(e.dcyc));
          chk("busy_cycles", 64'(busy_cnt),     64'(e.lat));
          held32 = e.f32; helds = e.fs; held8 = e.f8;
          heldo32 = e.o32; heldos = e.os; heldo8 = e.o8;
        end
        busy_cnt = 0;
      end else begin
        chk("f_held", {if32.f, ifs.f}, {held32, helds});
        chk("aux_held", {24'(if8.f), 5'd0, if32.overflow, ifs.overflow, if8.overflow},
            {24'(held8), 5'd0, heldo32, heldos, heldo8});
      end
      prev_done = if32.done;
    end
  end

  initial begin
    int unsigned nr;
    total = 0;
    bad = 0;
    rst = 1'b0;
    if32.start = 1'b0;
    if32.n = '0;
    repeat (3) @(negedge clk);
    chk("rst_f",     64'(if32.f),        64'd0);
    chk("rst_ovf",   64'(if32.overflow), 64'd0);
    chk("rst_done",  64'(if32.done),     64'd0);
    chk("rst_ready", 64'(if32.ready),    64'd1);
    chk("rst_busy",  64'(if32.busy),     64'd0);
    #2 rst = 1'b1;
    @(negedge clk);

    do_op(5, 1'b0);
    do_op(0, 1'b0);
    do_op(1, 1'b0);
    do_op(12, 1'b0);
    do_op(13, 1'b0);
    do_op(6, 1'b0);
    do_op(4, 1'b1);
    repeat (4) @(negedge clk);
    for (int i = 0; i < 30; i++) begin
      nr = ($urandom_range(0, 9) == 0) ? $urandom_range(21, 60) : $urandom_range(0, 20);
      do_op(nr, 1'b0);
      if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge clk);
    end
    drain();

    // Asynchronous reset in the middle of a long computation.
    do_op(10, 1'b0);
    repeat (3) @(negedge clk);
    #2 rst = 1'b0;
    #1;
    chk("arst_f",     64'(if32.f),        64'd0);
    chk("arst_ovf",   64'(if32.overflow), 64'd0);
    chk("arst_done",  64'(if32.done),     64'd0);
    chk("arst_ready", 64'(if32.ready),    64'd1);
    chk("arst_busy",  64'(if32.busy),     64'd0);
    sb_q.delete();
    @(negedge clk);
    #2 rst = 1'b1;
    @(negedge clk);
    do_op(3, 1'b0);
    drain();
    repeat (2) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
